// File: rtl/fft_mod_counter.sv
// Modulo-MODULUS stride counter with up/down, load and a pass counter for FFT stage sequencing.
// Optional macro BIT_REVERSE_EN adds out_rev, the bit-reversed view of out.
module fft_mod_counter #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 5,
    parameter int PASSES  = 3,
    parameter int PASS_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclr,
    input  logic              en,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [WIDTH-1:0]  step,
    input  logic              dir,
    output logic [WIDTH-1:0]  out,
`ifdef BIT_REVERSE_EN
    output logic [WIDTH-1:0]  out_rev,
`endif
    output logic              cout,
    output logic [PASS_W-1:0] pass_cnt,
    output logic              done,
    output logic              step_err
);

    // One extra bit so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]    MOD_W     = (WIDTH+1)'(MODULUS);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASSES - 1);

    logic [WIDTH-1:0]  out_q, out_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic              cout_q, cout_d;
    logic              done_q, done_d;
    logic              step_err_q, step_err_d;

    logic [WIDTH:0] cur_x, step_x, load_x, sum;

    always_comb begin
        cur_x      = {1'b0, out_q};
        step_x     = {1'b0, step};
        load_x     = {1'b0, load_val};
        sum        = cur_x + step_x;
        out_d      = out_q;
        pass_d     = pass_q;
        cout_d     = 1'b0;
        done_d     = 1'b0;
        step_err_d = 1'b0;

        if (sclr) begin
            out_d  = '0;
            pass_d = '0;
        end else if (load) begin
            out_d = (load_x < MOD_W) ? load_val : '0;
        end else if (en) begin
            if (step_x >= MOD_W) begin
                step_err_d = 1'b1;
            end else if (!dir) begin
                if (sum >= MOD_W) begin
                    out_d  = WIDTH'(sum - MOD_W);
                    cout_d = 1'b1;
                end else begin
                    out_d = WIDTH'(sum);
                end
            end else begin
                // step == 0 falls into the no-borrow branch and simply holds.
                if (out_q >= step) begin
                    out_d = out_q - step;
                end else begin
                    out_d  = WIDTH'(cur_x + MOD_W - step_x);
                    cout_d = 1'b1;
                end
            end

            if (cout_d) begin
                if (pass_q == PASS_LAST) begin
                    pass_d = '0;
                    done_d = 1'b1;
                end else begin
                    pass_d = pass_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= '0;
            pass_q     <= '0;
            cout_q     <= 1'b0;
            done_q     <= 1'b0;
            step_err_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            pass_q     <= pass_d;
            cout_q     <= cout_d;
            done_q     <= done_d;
            step_err_q <= step_err_d;
        end
    end

    assign out      = out_q;
    assign pass_cnt = pass_q;
    assign cout     = cout_q;
    assign done     = done_q;
    assign step_err = step_err_q;

`ifdef BIT_REVERSE_EN
    always_comb begin
        out_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            out_rev[i] = out_q[WIDTH-1-i];
        end
    end
`endif

endmodule

// File: tb/tb_fft_mod_counter.sv
// Directed bench for fft_mod_counter (WIDTH=3, MODULUS=5, PASSES=3).
module tb_fft_mod_counter;

    logic       clk = 1'b0;
    logic       rst_n, sclr, en, load, dir;
    logic [2:0] load_val, step;
    logic [2:0] out;
    logic       cout, done, step_err;
    logic [1:0] pass_cnt;
`ifdef BIT_REVERSE_EN
    logic [2:0] out_rev;
`endif

    int checks = 0;
    int errors = 0;

    fft_mod_counter #(.WIDTH(3), .MODULUS(5), .PASSES(3), .PASS_W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclr     (sclr),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .step     (step),
        .dir      (dir),
        .out      (out),
`ifdef BIT_REVERSE_EN
        .out_rev  (out_rev),
`endif
        .cout     (cout),
        .pass_cnt (pass_cnt),
        .done     (done),
        .step_err (step_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int o, input int c, input int p,
                           input int d, input int se);
        chk({tag, ".out"},      int'(out),      o);
        chk({tag, ".cout"},     int'(cout),     c);
        chk({tag, ".pass"},     int'(pass_cnt), p);
        chk({tag, ".done"},     int'(done),     d);
        chk({tag, ".step_err"}, int'(step_err), se);
    endtask

    initial begin
        int exp_out1[6]  = '{1, 2, 3, 4, 0, 1};
        int exp_cout1[6] = '{0, 0, 0, 0, 1, 0};
        int exp_pass1[6] = '{0, 0, 0, 0, 1, 1};
        int exp_out2[5]  = '{2, 4, 1, 3, 0};
        int exp_cout2[5] = '{0, 0, 1, 0, 1};
        int exp_pass2[5] = '{1, 1, 2, 2, 0};
        int exp_out3[6]  = '{4, 3, 2, 1, 0, 4};
        int exp_cout3[6] = '{1, 0, 0, 0, 0, 1};
        int exp_pass3[6] = '{1, 1, 1, 1, 1, 2};

        rst_n = 1'b0; sclr = 1'b0; en = 1'b0; load = 1'b0; dir = 1'b0;
        load_val = 3'd0; step = 3'd0;
        #12;
        chk_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: up by 1
        en = 1'b1; step = 3'd1; dir = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_all($sformatf("t1[%0d]", i), exp_out1[i], exp_cout1[i], exp_pass1[i], 0, 0);
        end

        // idle hold
        en = 1'b0;
        tick();
        chk_all("idle", 1, 0, 1, 0, 0);

        // 2: load 0 keeps pass_cnt, then up by 2
        load = 1'b1; load_val = 3'd0;
        tick();
        chk_all("t2.load", 0, 0, 1, 0, 0);
        load = 1'b0; en = 1'b1; step = 3'd2;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all($sformatf("t2[%0d]", i), exp_out2[i], exp_cout2[i], exp_pass2[i],
                    (i == 4) ? 1 : 0, 0);
        end

        // 3: down by 1 from 0, then down by 3 from 1
        step = 3'd1; dir = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_all($sformatf("t3[%0d]", i), exp_out3[i], exp_cout3[i], exp_pass3[i], 0, 0);
        end
        en = 1'b0; load = 1'b1; load_val = 3'd1;
        tick();
        chk_all("t3.load1", 1, 0, 2, 0, 0);
        load = 1'b0; en = 1'b1; step = 3'd3;
        tick();
        chk_all("t3.borrow3", 3, 1, 0, 1, 0);

        // step 0 holds with no pulses
        step = 3'd0; dir = 1'b0;
        tick();
        chk_all("step0", 3, 0, 0, 0, 0);

        // 4: clear then 15 up-steps of 1
        en = 1'b0; sclr = 1'b1;
        tick();
        chk_all("t4.sclr", 0, 0, 0, 0, 0);
        sclr = 1'b0; en = 1'b1; step = 3'd1; dir = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk_all($sformatf("t4[%0d]", k), k % 5, (k % 5 == 0) ? 1 : 0,
                    (k / 5) % 3, (k == 15) ? 1 : 0, 0);
        end

        // 5: load and clear
        en = 1'b0; load = 1'b1; load_val = 3'd6;
        tick();
        chk_all("t5.load6", 0, 0, 0, 0, 0);
        load_val = 3'd3; en = 1'b1; step = 3'd1;
        tick();
        chk_all("t5.load3en", 3, 0, 0, 0, 0);
        load = 1'b0; step = 3'd3;
        tick();
        chk_all("t5.up3", 1, 1, 1, 0, 0);
        sclr = 1'b1; load = 1'b1; load_val = 3'd2;
        tick();
        chk_all("t5.sclrload", 0, 0, 0, 0, 0);
        sclr = 1'b0; load = 1'b0; step = 3'd1;
        tick();
        tick();
        chk("t5.pre_rst", int'(out), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("t5.async_rst", 0, 0, 0, 0, 0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_all("t5.post_rst", 0, 0, 0, 0, 0);

        // 6: step out of range
        load = 1'b1; load_val = 3'd3;
        tick();
`ifdef BIT_REVERSE_EN
        chk("t6.rev3", int'(out_rev), 6);
`endif
        load = 1'b0; en = 1'b1; step = 3'd5;
        tick();
        chk_all("t6.step5", 3, 0, 0, 0, 1);
        en = 1'b0;
        tick();
        chk_all("t6.clear_err", 3, 0, 0, 0, 0);
        en = 1'b1; step = 3'd7; dir = 1'b1;
        tick();
        chk_all("t6.step7", 3, 0, 0, 0, 1);
        en = 1'b0; load = 1'b1; load_val = 3'd1;
        tick();
        chk_all("t6.load1", 1, 0, 0, 0, 0);
`ifdef BIT_REVERSE_EN
        chk("t6.rev1", int'(out_rev), 4);
`endif
        load = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
